// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-core-side signals of the UART TX round-robin arbiter.
// The arbiter uses the master modport; the requesters and the UART core use the slave modport.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_busy;
    logic                      tx_data_valid;
    logic [DATA_W-1:0]         tx_p_data;
    logic [SRC_W-1:0]          tx_src;
    logic                      tx_done;
    logic                      tx_err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data_valid, tx_p_data, tx_src, tx_done, tx_err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data_valid, tx_p_data, tx_src, tx_done, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core between NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to build the WAIT_BUSY watchdog that drives tx_err.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must fit the 8-bit watchdog");
    end

    state_t             state;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   next_ptr;
    logic               any_req;
    logic [SRC_W-1:0]   src_q;
    logic [DATA_W-1:0]  data_q;
    logic [NUM_REQ-1:0] ready_q;
    logic               dv_q;
    logic               done_q;
`ifdef UART_ARB_TIMEOUT_EN
    logic               err_q;
    logic [7:0]         wd_cnt;
`endif

    // Scan from ptr downwards in priority so the lowest rotated offset is written last and wins.
    always_comb begin : arbitrate
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.req_valid[SRC_W'(idx)]) begin
                winner = SRC_W'(idx);
            end
        end
    end

    assign any_req  = |bus.req_valid;
    assign next_ptr = (src_q == SRC_W'(NUM_REQ - 1)) ? '0 : src_q + SRC_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            src_q   <= '0;
            data_q  <= '0;
            ready_q <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            wd_cnt  <= '0;
`endif
        end else begin
            dv_q    <= 1'b0;
            ready_q <= '0;
            done_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req && !bus.tx_busy) begin
                        data_q  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
                        src_q   <= winner;
                        dv_q    <= 1'b1;
                        ready_q <= NUM_REQ'(1) << winner;
                        state   <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // The core never acknowledged the byte: give up and move past this requester.
                    else if (wd_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        err_q <= 1'b1;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        done_q <= 1'b1;
                        ptr    <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = ready_q;
    assign bus.tx_data_valid = dv_q;
    assign bus.tx_p_data     = data_q;
    assign bus.tx_src        = src_q;
    assign bus.tx_done       = done_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.tx_err        = err_q;
`else
    assign bus.tx_err        = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: reset, full frames, round-robin order,
// wrap/skip, busy-in-IDLE, mid-frame reset and (with UART_ARB_TIMEOUT_EN) the watchdog.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic busy);
        bus.req_valid = valid;
        bus.tx_busy   = busy;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dv"},    32'(bus.tx_data_valid), 32'd0);
        checkOutput({tag, "_ready"}, 32'(bus.req_ready),     32'd0);
        checkOutput({tag, "_data"},  32'(bus.tx_p_data),     32'd0);
        checkOutput({tag, "_src"},   32'(bus.tx_src),        32'd0);
        checkOutput({tag, "_done"},  32'(bus.tx_done),       32'd0);
        checkOutput({tag, "_err"},   32'(bus.tx_err),        32'd0);
    endtask

    // Expects a grant on the next negedge, then plays a UART core that is busy
    // for 10 cycles starting one cycle after Data_valid; returns on the tx_done negedge.
    task automatic runFrame(input int expSrc, input logic [7:0] expData);
        int dvCount;
        int doneCount;
        @(negedge clk);
        checkOutput("grant_dv",    32'(bus.tx_data_valid), 32'd1);
        checkOutput("grant_ready", 32'(bus.req_ready),     32'(4'b0001 << expSrc));
        checkOutput("grant_data",  32'(bus.tx_p_data),     32'(expData));
        checkOutput("grant_src",   32'(bus.tx_src),        32'(expSrc));
        dvCount   = 1;
        doneCount = 0;
        @(negedge clk);
        checkOutput("dv_one_cycle",    32'(bus.tx_data_valid), 32'd0);
        checkOutput("ready_one_cycle", 32'(bus.req_ready),     32'd0);
        bus.tx_busy = 1'b1;
        repeat (10) begin
            @(negedge clk);
            dvCount   += int'(bus.tx_data_valid);
            doneCount += int'(bus.tx_done);
        end
        bus.tx_busy = 1'b0;
        checkOutput("frame_dv_count",   32'(dvCount),   32'd1);
        checkOutput("frame_early_done", 32'(doneCount), 32'd0);
        @(negedge clk);
        checkOutput("frame_done",     32'(bus.tx_done), 32'd1);
        checkOutput("frame_err",      32'(bus.tx_err),  32'd0);
        checkOutput("frame_src_hold", 32'(bus.tx_src),  32'(expSrc));
    endtask

    initial begin
        bus.req_data = 32'h0000_00A5;
        applyStimulus(4'b0001, 1'b0);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        bus.req_valid = 4'b0001;
        runFrame(0, 8'hA5);

        // Fresh reset so round-robin starts from pointer 0.
        bus.req_data = 32'h1312_1110;
        applyStimulus(4'b1111, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        runFrame(0, 8'h10);
        runFrame(1, 8'h11);
        runFrame(2, 8'h12);
        runFrame(3, 8'h13);
        runFrame(0, 8'h10);

        applyStimulus(4'b0100, 1'b0);
        runFrame(2, 8'h12);
        applyStimulus(4'b0110, 1'b0);
        runFrame(1, 8'h11);
        runFrame(2, 8'h12);
        runFrame(1, 8'h11);

        applyStimulus(4'b0010, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("busy_idle_dv",    32'(bus.tx_data_valid), 32'd0);
            checkOutput("busy_idle_ready", 32'(bus.req_ready),     32'd0);
        end
        bus.tx_busy = 1'b0;
        runFrame(1, 8'h11);

        // Abandon a frame in WAIT_DONE with an asynchronous reset.
        applyStimulus(4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("midrst_grant_src", 32'(bus.tx_src), 32'd2);
        @(negedge clk);
        bus.tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 checkAllZero("midrst");
        applyStimulus(4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_no_grant", 32'(bus.tx_data_valid), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int errCount;
            int doneCount;
            errCount  = 0;
            doneCount = 0;
            applyStimulus(4'b0011, 1'b0);
            @(negedge clk);
            checkOutput("wd_grant_dv",  32'(bus.tx_data_valid), 32'd1);
            checkOutput("wd_grant_src", 32'(bus.tx_src),        32'd0);
            repeat (15) begin
                @(negedge clk);
                errCount  += int'(bus.tx_err);
                doneCount += int'(bus.tx_done);
            end
            checkOutput("wd_early_err", 32'(errCount), 32'd0);
            @(negedge clk);
            checkOutput("wd_err",  32'(bus.tx_err),  32'd1);
            checkOutput("wd_done", 32'(bus.tx_done + doneCount[0]), 32'd0);
            @(negedge clk);
            checkOutput("wd_err_pulse",  32'(bus.tx_err),        32'd0);
            checkOutput("wd_next_dv",    32'(bus.tx_data_valid), 32'd1);
            checkOutput("wd_next_src",   32'(bus.tx_src),        32'd1);
            checkOutput("wd_next_data",  32'(bus.tx_p_data),     32'h11);
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
